div_unit: RTL

//  Iterative radix-2 restoring divider for MIPS DIV/DIVU; E-stage responder to the hazard unit's div stall.

---
 rtl/div_unit_pkg.sv | 19 +
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit_step.sv | 17 +
 rtl/div_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared state codes and cycle constants for the iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int DIV_DATA_W = 32;

  // Request-to-complete latency: one restoring step per bit plus the accept cycle.
  function automatic int div_cycles(input int w);
    return w + 1;
  endfunction

  localparam int DIV_CYCLES = div_cycles(DIV_DATA_W);

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the E-stage (master) and the divider (slave).
interface div_unit_if #(
  parameter int DATA_W = 32
);
  logic              div;
  logic              div_signed;
  logic              div_cancel;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  logic              div_complete;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output div, div_signed, div_cancel, x, y,
    input  div_complete, quotient, remainder
  );

  modport slave (
    input  div, div_signed, div_cancel, x, y,
    output div_complete, quotient, remainder
  );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_rem,
  input  logic              i_bit,
  input  logic [DATA_W-1:0] i_dvs,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_qbit
);
  logic [DATA_W:0] w_part;

  assign w_part = {i_rem, i_bit};
  assign o_qbit = (w_part >= {1'b0, i_dvs});
  // The true difference is below the divisor, so the DATA_W-bit wrap-around subtract is exact.
  assign o_rem  = o_qbit ? (w_part[DATA_W-1:0] - i_dvs) : w_part[DATA_W-1:0];
endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle, pulse on completion.
// Optional build macro DIV_EARLY_OUT_EN: finish at accept when |x| < |y|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);
  localparam int CNT_W     = $clog2(DATA_W + 1);
  localparam int LAST_STEP = div_cycles(DATA_W) - 2;

  div_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_complete;
  logic              r_q_neg;
  logic              r_r_neg;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_remo;
  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_rem;

  logic [DATA_W-1:0] w_abs_x;
  logic [DATA_W-1:0] w_abs_y;
  logic [DATA_W-1:0] w_rem_nxt;
  logic              w_qbit;
  logic              w_accept;
  logic              w_x_neg;
  logic              w_y_neg;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  assign w_x_neg  = bus.div_signed & bus.x[DATA_W-1];
  assign w_y_neg  = bus.div_signed & bus.y[DATA_W-1];
  assign w_abs_x  = cond_neg(bus.x, w_x_neg);
  assign w_abs_y  = cond_neg(bus.y, w_y_neg);
  assign w_accept = (r_state == DIV_IDLE) && bus.div && !bus.div_cancel;

  div_step #(.DATA_W(DATA_W)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[DATA_W-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // Control and result registers; cancel overrides every state, including a same-cycle accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= DIV_IDLE;
      r_cnt      <= '0;
      r_complete <= 1'b0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_quo      <= '0;
      r_remo     <= '0;
    end else begin
      r_complete <= 1'b0;
      if (bus.div_cancel) begin
        r_state <= DIV_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          DIV_IDLE: begin
            if (bus.div) begin
              r_q_neg <= w_x_neg ^ w_y_neg;
              r_r_neg <= w_x_neg;
              r_cnt   <= '0;
`ifdef DIV_EARLY_OUT_EN
              if (w_abs_x < w_abs_y) begin
                r_state    <= DIV_DONE;
                r_complete <= 1'b1;
                r_quo      <= '0;
                r_remo     <= bus.x;
              end else begin
                r_state <= DIV_BUSY;
              end
`else
              r_state <= DIV_BUSY;
`endif
            end
          end
          DIV_BUSY: begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LAST_STEP)) begin
              r_state    <= DIV_DONE;
              r_complete <= 1'b1;
              r_quo      <= cond_neg({r_dvd[DATA_W-2:0], w_qbit}, r_q_neg);
              r_remo     <= cond_neg(w_rem_nxt, r_r_neg);
            end
          end
          // The request still high here belongs to the finishing instruction.
          DIV_DONE: r_state <= DIV_IDLE;
          default:  r_state <= DIV_IDLE;
        endcase
      end
    end
  end

  // Datapath shift registers: dividend bits leave at the top while quotient bits enter at the bottom.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dvd <= w_abs_x;
      r_dvs <= w_abs_y;
      r_rem <= '0;
    end else if (r_state == DIV_BUSY) begin
      r_dvd <= {r_dvd[DATA_W-2:0], w_qbit};
      r_rem <= w_rem_nxt;
    end
  end

  assign bus.div_complete = r_complete;
  assign bus.quotient     = r_quo;
  assign bus.remainder    = r_remo;
endmodule
